// File: rtl/pong_game_ctrl_if.sv
// Event/control bundle between the pong game sequencer and its pixel generator.
// The slave side is the sequencer; the master side supplies frame ticks and game events.
interface pong_game_ctrl_if #(
  parameter int LIFE_BITS  = 2,
  parameter int SCORE_BITS = 8
);
  logic                  refresh_tick;
  logic                  start;
  logic                  hit;
  logic                  miss;
  logic                  ball_reset;
  logic                  ball_en;
  logic                  game_over;
  logic [SCORE_BITS-1:0] score;
  logic [LIFE_BITS-1:0]  lives_left;
  logic [1:0]            state;

  modport master (
    output refresh_tick, start, hit, miss,
    input  ball_reset, ball_en, game_over, score, lives_left, state
  );

  modport slave (
    input  refresh_tick, start, hit, miss,
    output ball_reset, ball_en, game_over, score, lives_left, state
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Frame-rate pong game sequencer: idle/serve/play/over, score and lives bookkeeping.
// Every output comes straight from a register; nothing is combinational from inputs.
module pong_game_ctrl #(
  parameter int LIVES              = 3,
  parameter int LIFE_BITS          = 2,
  parameter int SCORE_BITS         = 8,
  parameter int SERVE_DELAY_FRAMES = 60,
  parameter int OVER_HOLD_FRAMES   = 120,
  parameter int TIMER_BITS         = 8
) (
  input  logic clk,
  input  logic reset,
  pong_game_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam logic [LIFE_BITS-1:0]  LIVES_INIT = LIFE_BITS'(LIVES);
  localparam logic [LIFE_BITS-1:0]  LIFE_ONE   = LIFE_BITS'(1);
  localparam logic [LIFE_BITS-1:0]  LIFE_ZERO  = {LIFE_BITS{1'b0}};
  localparam logic [TIMER_BITS-1:0] SERVE_LOAD = TIMER_BITS'(SERVE_DELAY_FRAMES);
  localparam logic [TIMER_BITS-1:0] OVER_LOAD  = TIMER_BITS'(OVER_HOLD_FRAMES);
  localparam logic [TIMER_BITS-1:0] TIMER_ONE  = TIMER_BITS'(1);
  localparam logic [TIMER_BITS-1:0] TIMER_ZERO = {TIMER_BITS{1'b0}};
  localparam logic [SCORE_BITS-1:0] SCORE_MAX  = {SCORE_BITS{1'b1}};
  localparam logic [SCORE_BITS-1:0] SCORE_ONE  = SCORE_BITS'(1);
  localparam logic [SCORE_BITS-1:0] SCORE_ZERO = {SCORE_BITS{1'b0}};

  state_t                state_r;
  logic [TIMER_BITS-1:0] timer_r;
  logic [SCORE_BITS-1:0] score_r;
  logic [LIFE_BITS-1:0]  lives_r;
  logic                  start_d_r;
  logic [2:0]            outs_r;     // {ball_reset, ball_en, game_over}
  logic                  start_pe_s;

  // Saturating score increment.
  function automatic logic [SCORE_BITS-1:0] sat_inc(input logic [SCORE_BITS-1:0] v);
    if (v == SCORE_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + SCORE_ONE;
    end
  endfunction

  // Output decode for a state, loaded together with the state so outputs stay registered.
  function automatic logic [2:0] decode(input state_t s);
    case (s)
      ST_IDLE:  decode = 3'b100;
      ST_SERVE: decode = 3'b100;
      ST_PLAY:  decode = 3'b010;
      ST_OVER:  decode = 3'b101;
      default:  decode = 3'b100;
    endcase
  endfunction

  assign start_pe_s = bus.start & ~start_d_r;

  // Game sequencer: state, frame timer, score, lives and start-edge register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      outs_r    <= 3'b100;
      timer_r   <= TIMER_ZERO;
      score_r   <= SCORE_ZERO;
      lives_r   <= LIVES_INIT;
      start_d_r <= 1'b0;
    end else begin
      start_d_r <= bus.start;
      case (state_r)
        ST_IDLE: begin
          if (start_pe_s) begin
            state_r <= ST_SERVE;
            outs_r  <= decode(ST_SERVE);
            score_r <= SCORE_ZERO;
            lives_r <= LIVES_INIT;
            timer_r <= SERVE_LOAD;
          end
        end
        ST_SERVE: begin
          if (bus.refresh_tick) begin
            timer_r <= timer_r - TIMER_ONE;
            if (timer_r == TIMER_ONE) begin
              state_r <= ST_PLAY;
              outs_r  <= decode(ST_PLAY);
            end
          end
        end
        ST_PLAY: begin
          // A miss takes priority; a coincident hit is discarded.
          if (bus.miss) begin
            if (lives_r > LIFE_ONE) begin
              lives_r <= lives_r - LIFE_ONE;
              state_r <= ST_SERVE;
              outs_r  <= decode(ST_SERVE);
              timer_r <= SERVE_LOAD;
            end else begin
              lives_r <= LIFE_ZERO;
              state_r <= ST_OVER;
              outs_r  <= decode(ST_OVER);
              timer_r <= OVER_LOAD;
            end
          end else if (bus.hit) begin
            score_r <= sat_inc(score_r);
          end
        end
        ST_OVER: begin
          if (bus.refresh_tick) begin
            timer_r <= timer_r - TIMER_ONE;
            if (timer_r == TIMER_ONE) begin
              state_r <= ST_IDLE;
              outs_r  <= decode(ST_IDLE);
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          outs_r  <= decode(ST_IDLE);
        end
      endcase
    end
  end

  assign bus.ball_reset = outs_r[2];
  assign bus.ball_en    = outs_r[1];
  assign bus.game_over  = outs_r[0];
  assign bus.score      = score_r;
  assign bus.lives_left = lives_r;
  assign bus.state      = state_r;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: directed vector table, corner sequences and
// randomized play against a behavioural model; runs an 8-bit-score and a 3-bit-score DUT in lockstep.
module tb_pong_game_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick = 1'b0;
  logic start = 1'b0;
  logic hit = 1'b0;
  logic miss = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  pong_game_ctrl_if #(.LIFE_BITS(2), .SCORE_BITS(8)) if8 ();
  pong_game_ctrl_if #(.LIFE_BITS(2), .SCORE_BITS(3)) if3 ();

  assign if8.refresh_tick = tick;
  assign if8.start        = start;
  assign if8.hit          = hit;
  assign if8.miss         = miss;
  assign if3.refresh_tick = tick;
  assign if3.start        = start;
  assign if3.hit          = hit;
  assign if3.miss         = miss;

  pong_game_ctrl #(.LIVES(3), .LIFE_BITS(2), .SCORE_BITS(8), .SERVE_DELAY_FRAMES(2),
                   .OVER_HOLD_FRAMES(3), .TIMER_BITS(8))
    dut8 (.clk(clk), .reset(reset), .bus(if8));

  pong_game_ctrl #(.LIVES(3), .LIFE_BITS(2), .SCORE_BITS(3), .SERVE_DELAY_FRAMES(2),
                   .OVER_HOLD_FRAMES(3), .TIMER_BITS(8))
    dut3 (.clk(clk), .reset(reset), .bus(if3));

  always #5 clk = ~clk;

  // Behavioural model: mode 0 idle, 1 waiting for serve, 2 ball live, 3 game over.
  int m_mode;
  int m_frames;
  int m_hits;
  int m_lives;
  bit m_start_d;

  task automatic model_reset();
    m_mode = 0; m_frames = 0; m_hits = 0; m_lives = 3; m_start_d = 1'b0;
  endtask

  task automatic model_step();
    bit pe;
    pe = start && !m_start_d;
    m_start_d = start;
    if (m_mode == 0) begin
      if (pe) begin m_mode = 1; m_hits = 0; m_lives = 3; m_frames = 2; end
    end else if (m_mode == 1 || m_mode == 3) begin
      if (tick) begin
        m_frames = m_frames - 1;
        if (m_frames == 0) m_mode = (m_mode == 1) ? 2 : 0;
      end
    end else begin
      if (miss) begin
        if (m_lives > 1) begin m_lives = m_lives - 1; m_mode = 1; m_frames = 2; end
        else begin m_lives = 0; m_mode = 3; m_frames = 3; end
      end else if (hit) begin
        m_hits = m_hits + 1;
      end
    end
  endtask

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, " state8"}, int'(if8.state), m_mode);
    chk({ctx, " state3"}, int'(if3.state), m_mode);
    chk({ctx, " ball_reset"}, int'(if8.ball_reset), (m_mode != 2) ? 1 : 0);
    chk({ctx, " ball_en"}, int'(if8.ball_en), (m_mode == 2) ? 1 : 0);
    chk({ctx, " game_over"}, int'(if8.game_over), (m_mode == 3) ? 1 : 0);
    chk({ctx, " ball_en3"}, int'(if3.ball_en), (m_mode == 2) ? 1 : 0);
    chk({ctx, " score8"}, int'(if8.score), min_int(m_hits, 255));
    chk({ctx, " score3"}, int'(if3.score), min_int(m_hits, 7));
    chk({ctx, " lives8"}, int'(if8.lives_left), m_lives);
    chk({ctx, " lives3"}, int'(if3.lives_left), m_lives);
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, settle.
  task automatic step(input bit s, input bit t, input bit h, input bit m);
    start = s; tick = t; hit = h; miss = m;
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Asynchronous reset asserted between edges, checked before any clock edge arrives.
  task automatic do_reset(input string ctx);
    @(negedge clk);
    #2 reset = 1'b1;
    model_reset();
    #1;
    check_all(ctx);
    chk({ctx, " async state"}, int'(if8.state), 0);
    chk({ctx, " async lives"}, int'(if8.lives_left), 3);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    bit s; bit t; bit h; bit m;
    int st; int sc; int lv;
  } vec_t;

  function automatic vec_t v(input bit s, input bit t, input bit h, input bit m,
                             input int st, input int sc, input int lv);
    vec_t r;
    r.s = s; r.t = t; r.h = h; r.m = m; r.st = st; r.sc = sc; r.lv = lv;
    return r;
  endfunction

  vec_t tbl [24];

  initial begin
    tbl[0]  = v(0,1,0,0, 0,0,3);
    tbl[1]  = v(0,0,1,1, 0,0,3);   // events in idle are dropped
    tbl[2]  = v(1,0,0,0, 1,0,3);   // start edge -> serve
    tbl[3]  = v(1,1,0,0, 1,0,3);
    tbl[4]  = v(1,0,1,1, 1,0,3);   // events in serve are dropped
    tbl[5]  = v(1,1,0,0, 2,0,3);   // second tick -> play
    tbl[6]  = v(1,0,1,0, 2,1,3);
    tbl[7]  = v(0,1,1,0, 2,2,3);
    tbl[8]  = v(0,0,1,0, 2,3,3);
    tbl[9]  = v(0,0,1,0, 2,4,3);
    tbl[10] = v(1,0,1,0, 2,5,3);   // start edge in play ignored
    tbl[11] = v(0,0,1,1, 1,5,2);   // miss wins over hit
    tbl[12] = v(0,1,0,0, 1,5,2);
    tbl[13] = v(0,1,0,0, 2,5,2);
    tbl[14] = v(0,0,0,1, 1,5,1);
    tbl[15] = v(0,1,0,0, 1,5,1);
    tbl[16] = v(0,1,0,0, 2,5,1);
    tbl[17] = v(0,1,0,1, 3,5,0);   // last ball lost
    tbl[18] = v(1,1,1,1, 3,5,0);   // start edge and events in over ignored
    tbl[19] = v(0,0,0,0, 3,5,0);
    tbl[20] = v(0,1,0,0, 3,5,0);
    tbl[21] = v(0,1,0,0, 0,5,0);   // third tick -> idle, score/lives held
    tbl[22] = v(0,0,0,0, 0,5,0);
    tbl[23] = v(1,0,0,0, 1,0,3);   // new game clears score and lives

    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      check_all("idle");
    end

    for (int i = 0; i < 24; i++) begin
      step(tbl[i].s, tbl[i].t, tbl[i].h, tbl[i].m);
      check_all("tbl");
      chk($sformatf("tbl[%0d] state", i), int'(if8.state), tbl[i].st);
      chk($sformatf("tbl[%0d] score", i), int'(if8.score), tbl[i].sc);
      chk($sformatf("tbl[%0d] score3", i), int'(if3.score), min_int(tbl[i].sc, 7));
      chk($sformatf("tbl[%0d] lives", i), int'(if8.lives_left), tbl[i].lv);
    end

    // Saturation: 9 hits in play, 3-bit score sticks at 7.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("sat enter play", int'(if8.state), 2);
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      check_all("sat");
    end
    chk("sat score3", int'(if3.score), 7);
    chk("sat score8", int'(if8.score), 9);

    // Start held through reset release gives exactly one start edge.
    start = 1'b1;
    do_reset("rst1");
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("held start serve", int'(if8.state), 1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
    check_all("pre-rst");
    chk("pre-rst state", int'(if8.state), 2);
    chk("pre-rst score", int'(if8.score), 4);
    chk("pre-rst lives", int'(if8.lives_left), 1);
    start = 1'b0;
    hit = 1'b1;
    do_reset("rst2");
    chk("rst2 ball_en", int'(if8.ball_en), 0);
    chk("rst2 score", int'(if8.score), 0);

    // Randomized play against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset("rand rst");
      end else begin
        step(($urandom_range(0, 7) == 0) ? ~start : start,
             ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 9) == 0));
        check_all("rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Frame-rate game sequencer for the pong playfield. Owns game state (idle / serve / play / game over), score and remaining lives. Drives the ball-hold and ball-enable controls of the pixel generator. Consumes its per-frame refresh tick and its paddle-hit and ball-miss event pulses.

Parameters:
LIVES, 3, balls per game; legal range 1..(2**LIFE_BITS - 1)
LIFE_BITS, 2, width of lives counter
SCORE_BITS, 8, width of score counter
SERVE_DELAY_FRAMES, 60, refresh ticks the ball is held before each serve; must be >= 1
OVER_HOLD_FRAMES, 120, refresh ticks spent in OVER before returning to IDLE; must be >= 1
TIMER_BITS, 8, width of frame timer; must hold max(SERVE_DELAY_FRAMES, OVER_HOLD_FRAMES)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
refresh_tick  input  1  one-cycle pulse per frame (start of vertical retrace)
start  input  1  start button, level, already synchronized to clk
hit  input  1  one-cycle pulse: ball struck paddle
miss  input  1  one-cycle pulse: ball left playfield past paddle
ball_reset  output  1  1 = hold ball at serve position
ball_en  output  1  1 = ball motion enabled
game_over  output  1  1 while in OVER
score  output  SCORE_BITS  hits this game
lives_left  output  LIFE_BITS  balls remaining
state  output  2  IDLE=0, SERVE=1, PLAY=2, OVER=3 (debug)

Behaviour:
- All state is registered. All outputs are registered or decoded from the state register only (Moore). Nothing combinational from inputs to outputs.
- Reset (async) values: state=IDLE, score=0, lives_left=LIVES, timer=0, start_d=0.
- Decoded outputs:
  - ball_reset=1 in IDLE, SERVE and OVER.
  - ball_en=1 only in PLAY.
  - game_over=1 only in OVER.
- Start edge: start_pe = start & ~start_d, where start_d is a register.
  - If start is already high on the first cycle after reset release, it produces one start_pe.
  - A held start produces no further pulses.
- IDLE:
  - On start_pe: go to SERVE; score<=0; lives_left<=LIVES; timer<=SERVE_DELAY_FRAMES.
  - All other inputs are ignored.
- SERVE:
  - On each refresh_tick: timer<=timer-1.
  - On a refresh_tick with timer==1: go to PLAY with timer<=0.
  - With SERVE_DELAY_FRAMES=N, PLAY is entered the cycle after the Nth tick following SERVE entry.
  - hit, miss and start are ignored.
- PLAY:
  - hit: score<=score+1, saturating at 2**SCORE_BITS-1. Visible the cycle after the pulse.
  - miss with lives_left>1: lives_left<=lives_left-1; go to SERVE; timer<=SERVE_DELAY_FRAMES.
  - miss with lives_left==1: lives_left<=0; go to OVER; timer<=OVER_HOLD_FRAMES.
  - hit and miss in the same cycle: miss wins and the hit is discarded (score unchanged).
  - start is ignored.
- OVER:
  - Decrement timer on refresh_tick. On the tick with timer==1, go to IDLE.
  - score and lives_left are held until the next start_pe in IDLE.
  - start_pe is ignored while in OVER.
- refresh_tick coincident with hit/miss in PLAY: no interaction; the event is processed normally.
- hit/miss pulses outside PLAY are dropped, never queued.
- Reset asserted mid-game: immediate return to reset values regardless of state; no pending event survives.
- Width rules:
  - Timer, score and lives arithmetic is unsigned and modulo its own width, except for score saturation.
  - lives_left never decrements below 0.

Test Plan:
- Params LIVES=3, SERVE_DELAY_FRAMES=2, OVER_HOLD_FRAMES=3 for all tests.
- Reset then idle: no start for 10 ticks -> state=0, ball_reset=1, ball_en=0, score=0, lives_left=3.
- Start pulse, then 2 refresh_ticks -> state=1 for exactly 2 ticks; state=2, ball_en=1, ball_reset=0 on the cycle after the 2nd tick; start held high produces no second start_pe.
- In PLAY, 5 hit pulses, then hit+miss in the same cycle -> score=5 (coincident hit dropped), lives_left=2, state=1, timer reloaded to 2.
- Three misses, each following re-entry into PLAY -> lives_left 2,1,0; after the 3rd miss state=3, game_over=1. After 3 ticks state=0, with score and lives_left still 5 and 0. Next start_pe -> score=0, lives_left=3.
- SCORE_BITS=3: 9 hits in PLAY -> score sticks at 7. Hits and misses injected during SERVE and OVER -> no change to score or lives_left.
- Assert reset in PLAY with score=4, lives_left=1 -> same-cycle async clear to state=0, score=0, lives_left=3, ball_en=0.
